// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx -- SPART serial receiver (8N1, LSB first, OVS-times oversampled)
//
// Recovers asynchronous frames (1 start bit, DW data bits, 1 stop bit) from
// the pad-side rxd line. Receive timing advances only on baud_tick, the
// oversampling enable from the baud-rate down-counter. Reset, the read
// handshake and the input synchronizer run on every clk.
//
// Handshake: rdy is the "valid" flag for rx_data. The consumer takes the byte
// by pulsing rd_en for one clk. At the next edge rdy, overrun and framing_err
// clear. If a byte completes on that same edge, the new byte is loaded and rdy
// stays set. This case does not count as an overrun. rd_en with rdy low only
// clears the sticky error flags.
//
// Parameters:
//   OVS  oversample ticks per bit (power of two, >= 4)
//   DW   data bits per frame (>= 2)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset (priority over everything)
//   baud_tick    one-clk enable pulse, OVS pulses per bit time
//   rxd          asynchronous serial input, idle high
//   rd_en        consumer read strobe, one-cycle pulse
//   rx_data      last accepted byte
//   rdy          rx_data holds an unread byte
//   framing_err  sticky: a stop bit was sampled low
//   overrun      sticky: a completed byte was dropped while rdy was set
//   state_dbg    receiver FSM state
//                (0 IDLE, 1 START, 2 DATA, 3 STOP, 4 BREAK)
// -----------------------------------------------------------------------------
module spart_rx #(
  parameter int OVS = 16,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_tick,
  input  logic          rxd,
  input  logic          rd_en,
  output logic [DW-1:0] rx_data,
  output logic          rdy,
  output logic          framing_err,
  output logic          overrun,
  output logic [2:0]    state_dbg
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  // tcnt value on the tick that samples the centre of a data or stop bit.
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  // tcnt value on the tick that samples the centre of the start bit.
  localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [DW-1:0] shreg;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Both flops reset to the idle (high) line level, so
  // leaving reset can never look like a start edge.
  // ---------------------------------------------------------------------------
  logic rxd_meta;
  logic rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  // The tick on which the stop bit is sampled. The whole output side updates
  // on this edge.
  logic stop_sample;
  assign stop_sample = baud_tick && (state == S_STOP) && (tcnt == T_LAST);

  // ---------------------------------------------------------------------------
  // Receiver FSM, counters, shift register and registered outputs.
  // tcnt is a power-of-two wide counter, so tcnt + 1 wraps OVS-1 -> 0 by
  // itself. This gives the 0 start value that each following bit period needs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rdy         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (baud_tick) begin
        case (state)
          S_IDLE: begin
            if (!rxs) begin
              state <= S_START;
              tcnt  <= '0;
            end
          end

          S_START: begin
            if (tcnt == T_MID) begin
              // Mid start bit: a high line here was only a glitch.
              tcnt  <= '0;
              bcnt  <= '0;
              state <= rxs ? S_IDLE : S_DATA;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end

          S_DATA: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == T_LAST) begin
              // LSB arrives first. After DW shifts it sits at bit 0.
              shreg <= {rxs, shreg[DW-1:1]};
              if (bcnt == B_LAST) begin
                bcnt  <= '0;
                state <= S_STOP;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end

          S_STOP: begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == T_LAST) begin
              state <= rxs ? S_IDLE : S_BREAK;
            end
          end

          S_BREAK: begin
            // Wait for the line to return high. A line held low must not
            // look like a continuous stream of start bits.
            if (rxs) begin
              state <= S_IDLE;
            end
          end

          default: begin
            state <= S_IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
          end
        endcase
      end

      // A read clears the sticky flags and consumes the byte. A completion on
      // the same edge is written after this, so it wins.
      if (rd_en) begin
        rdy         <= 1'b0;
        overrun     <= 1'b0;
        framing_err <= 1'b0;
      end

      if (stop_sample) begin
        if (rxs) begin
          if (!rdy || rd_en) begin
            rx_data <= shreg;
            rdy     <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          framing_err <= 1'b1;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_spart_rx.sv
// -----------------------------------------------------------------------------
// tb_spart_rx -- self-checking bench for spart_rx (OVS=16, DW=8).
//
// Timing of the line: the bench produces baud_tick itself, one tick every
// 4 clk. Each group of 4 clk is a "slot". Every rxd change happens at the
// start of a slot. One bit lasts OVS slots. The reference model works on
// whole frames: it knows the slot on which the stop bit is sampled, and it
// applies the read/complete rules at frame level.
// -----------------------------------------------------------------------------
module tb_spart_rx;

  localparam int OVS         = 16;
  localparam int DW          = 8;
  localparam int FRAME_SLOTS = 10 * OVS;
  // rxd set at the start of slot j is first seen by the tick of slot j+1
  // (2-flop synchronizer). The start bit is therefore detected on slot 1.
  // The stop-bit centre comes OVS/2 + 9*OVS ticks later.
  localparam int DONE_SLOT   = 1 + OVS / 2 + 9 * OVS;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          baud_tick;
  logic          rxd;
  logic          rd_en;
  logic [DW-1:0] rx_data;
  logic          rdy;
  logic          framing_err;
  logic          overrun;
  logic [2:0]    state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spart_rx #(.OVS(OVS), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .rx_data     (rx_data),
    .rdy         (rdy),
    .framing_err (framing_err),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];   // bytes accepted into rx_data, oldest first
  logic          m_rdy;
  logic          m_fe;
  logic          m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_rdy = 1'b0;
    m_fe  = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic m_read();
    m_rdy = 1'b0;
    m_fe  = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Frame-level rule: a good stop bit delivers the byte if the holding
  // register is free or is being read on the same edge. Otherwise the byte
  // is dropped as an overrun. A bad stop bit discards the byte and flags it.
  task automatic m_complete(input logic [DW-1:0] data, input logic stop_ok, input logic rd);
    logic was_rdy;
    was_rdy = m_rdy;
    if (rd) m_read();
    if (stop_ok) begin
      if (!was_rdy || rd) begin
        exp_q.push_back(data);
        m_rdy = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [DW-1:0] exp_data;
    exp_data = (exp_q.size() == 0) ? '0 : exp_q[exp_q.size()-1];
    check({tag, "_data"}, 32'(rx_data), 32'(exp_data));
    check({tag, "_rdy"},  32'(rdy),     32'(m_rdy));
    check({tag, "_fe"},   32'(framing_err), 32'(m_fe));
    check({tag, "_ovr"},  32'(overrun), 32'(m_ovr));
  endtask

  // ---------------- driver tasks ----------------
  // One slot: tick on its first clk, then 3 quiet clks. The caller is at a
  // negedge on entry and exit.
  task automatic slot(input logic rd);
    baud_tick = 1'b1;
    rd_en     = rd;
    @(negedge clk);
    baud_tick = 1'b0;
    rd_en     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic line_slots(input logic level, input int n, input int rd_slot);
    for (int i = 0; i < n; i++) begin
      rxd = level;
      if (i == rd_slot) m_read();
      slot(i == rd_slot);
    end
  endtask

  // rd_slot: slot at which rd_en is pulsed with the tick (-1 = none).
  // rst_slot: slot at which a one-clk reset is applied (-1 = none).
  task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit,
                            input int rd_slot, input int rst_slot);
    logic aborted;
    logic do_rd;
    aborted = 1'b0;
    for (int i = 0; i < FRAME_SLOTS; i++) begin
      int b;
      b = i / OVS;
      if (b == 0)       rxd = 1'b0;
      else if (b <= DW) rxd = data[b-1];
      else              rxd = stop_bit;
      if (i == rst_slot) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        aborted = 1'b1;
        check("midrst_data", 32'(rx_data), 32'h0);
        check("midrst_rdy",  32'(rdy), 32'h0);
        check("midrst_fe",   32'(framing_err), 32'h0);
        check("midrst_ovr",  32'(overrun), 32'h0);
        check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
      end
      do_rd = (i == rd_slot);
      if (i == DONE_SLOT) begin
        if (!aborted) m_complete(data, stop_bit, do_rd);
        else if (do_rd) m_read();
      end else if (do_rd) begin
        m_read();
      end
      slot(do_rd);
    end
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    m_read();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; baud_tick = 1'b0; rxd = 1'b1; rd_en = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_rdy",   32'(rdy), 32'h0);
    check("rst_fe",    32'(framing_err), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    line_slots(1'b1, 4, -1);

    // Clean byte, then read.
    send_frame(8'hA5, 1'b1, -1, -1);
    check("clean_data", 32'(rx_data), 32'hA5);
    check("clean_rdy",  32'(rdy), 32'h1);
    check("clean_fe",   32'(framing_err), 32'h0);
    check("clean_ovr",  32'(overrun), 32'h0);
    read_pulse();
    check("read_rdy",  32'(rdy), 32'h0);
    check("read_data", 32'(rx_data), 32'hA5);

    // Glitch: 5 low slots, then idle. No start is accepted.
    line_slots(1'b0, 5, -1);
    line_slots(1'b1, 16, -1);
    check("glitch_rdy",   32'(rdy), 32'h0);
    check("glitch_state", 32'(state_dbg), 32'(ST_IDLE));
    send_frame(8'h3C, 1'b1, -1, -1);
    check("post_glitch_data", 32'(rx_data), 32'h3C);
    check("post_glitch_rdy",  32'(rdy), 32'h1);
    read_pulse();

    // Framing error followed by a line held low for 3 more bit times.
    send_frame(8'h3C, 1'b0, -1, -1);
    line_slots(1'b0, 3 * OVS, -1);
    check("fe_flag",  32'(framing_err), 32'h1);
    check("fe_rdy",   32'(rdy), 32'h0);
    check("fe_data",  32'(rx_data), 32'h3C);
    check("fe_state", 32'(state_dbg), 32'(ST_BREAK));
    line_slots(1'b1, 4, -1);
    check("fe_release_state", 32'(state_dbg), 32'(ST_IDLE));
    send_frame(8'h5A, 1'b1, -1, -1);
    check("fe_next_data", 32'(rx_data), 32'h5A);
    check("fe_next_rdy",  32'(rdy), 32'h1);
    check("fe_sticky",    32'(framing_err), 32'h1);
    read_pulse();
    check("fe_clear", 32'(framing_err), 32'h0);
    check("fe_clear_rdy", 32'(rdy), 32'h0);

    // Overrun: two frames back to back with no read.
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_rdy",  32'(rdy), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    read_pulse();
    check("ovr_clear_rdy", 32'(rdy), 32'h0);
    check("ovr_clear_ovr", 32'(overrun), 32'h0);

    // Read on the exact completion edge of the next byte.
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, DONE_SLOT, -1);
    check("simul_data", 32'(rx_data), 32'h22);
    check("simul_rdy",  32'(rdy), 32'h1);
    check("simul_ovr",  32'(overrun), 32'h0);

    // Reset during data bit 4 (slots 5*OVS..6*OVS-1).
    send_frame(8'hF0, 1'b1, -1, 5 * OVS + 5);
    check("abort_rdy",   32'(rdy), 32'h0);
    check("abort_data",  32'(rx_data), 32'h0);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    send_frame(8'h81, 1'b1, -1, -1);
    check("fresh_data", 32'(rx_data), 32'h81);
    check("fresh_rdy",  32'(rdy), 32'h1);
    compare_model("directed_end");

    // Randomized frames against the frame-level model.
    for (int k = 0; k < 24; k++) begin
      logic [DW-1:0] data;
      logic          stop_ok;
      int            rd_slot;
      int            gap;
      data    = DW'($urandom_range(0, (1 << DW) - 1));
      stop_ok = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0:       rd_slot = -1;
        1:       rd_slot = DONE_SLOT;
        default: rd_slot = $urandom_range(0, FRAME_SLOTS - 1);
      endcase
      send_frame(data, stop_ok, rd_slot, -1);
      compare_model($sformatf("rnd%0d", k));
      gap = stop_ok ? $urandom_range(0, 3) : $urandom_range(2, 5);
      line_slots(1'b1, gap, ($urandom_range(0, 3) == 0) ? 0 : -1);
    end
    line_slots(1'b1, 4, -1);
    compare_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
